// File: rtl/raytrace_pkg.sv
// Shared types for the ray-trace pixel path: pixel coordinate struct and sequencer states.
package raytrace_pkg;
  localparam int COORD_W  = 12;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } Pixel_s;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} seq_state_e;
endpackage

// File: rtl/hit_result_fifo.sv
// Synchronous FIFO for (addr, hit) results; registered storage, no read bypass, occupancy output.
module hit_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ray_pixel_sequencer.sv
// Raster sweep into RayTraceCore, fixed-latency hit capture, credit-limited framebuffer writes.
module ray_pixel_sequencer
  import raytrace_pkg::*;
#(
  parameter int H_RES        = SCREEN_W,
  parameter int V_RES        = SCREEN_H,
  parameter int FOCAL_Z      = 15,
  parameter int CORE_LATENCY = 4,
  parameter int FIFO_DEPTH   = 8,
  localparam int AW          = $clog2(H_RES*V_RES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output Pixel_s        pixel,
  output logic          pixel_issue,
  input  logic          less_than_zero,
  output logic          fb_we,
  input  logic          fb_ready,
  output logic [AW-1:0] fb_addr,
  output logic          fb_data
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int FW = AW + 1;
  localparam logic signed [COORD_W-1:0] X0 = COORD_W'(-(H_RES/2));
  localparam logic signed [COORD_W-1:0] XL = COORD_W'(H_RES/2 - 1);
  localparam logic signed [COORD_W-1:0] Y0 = COORD_W'(V_RES/2);

  seq_state_e state_q, state_d;
  Pixel_s     pixel_q;
  logic [AW-1:0] addr_q;
  logic [CORE_LATENCY:1]         vld_pipe;
  logic [CORE_LATENCY:1][AW-1:0] addr_pipe;
  logic [CW:0]   inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [FW-1:0] fifo_out;
  logic          last_pix, credit_ok;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= CORE_LATENCY; i++)
      inflight = inflight + (CW+1)'(vld_pipe[i]);
  end

  // one credit per FIFO slot: everything in flight must fit once it lands
  assign credit_ok   = (inflight + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);
  assign pixel_issue = (state_q == SCAN) && credit_ok;
  assign last_pix    = (addr_q == AW'(H_RES*V_RES-1));
  assign pixel       = pixel_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (pixel_issue && last_pix) state_d = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pixel_q always holds the next sample to issue; it only moves on an issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q <= '0;
      addr_q  <= '0;
    end else if (state_q == IDLE && start) begin
      pixel_q.x <= X0;
      pixel_q.y <= Y0;
      pixel_q.z <= COORD_W'(FOCAL_Z);
      addr_q    <= '0;
    end else if (pixel_issue && !last_pix) begin
      addr_q <= addr_q + AW'(1);
      if (pixel_q.x == XL) begin
        pixel_q.x <= X0;
        pixel_q.y <= pixel_q.y - COORD_W'(1);
      end else begin
        pixel_q.x <= pixel_q.x + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= pixel_issue;
      addr_pipe[1] <= addr_q;
      for (int i = 2; i <= CORE_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  hit_result_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_pipe[CORE_LATENCY]),
    .push_data ({addr_pipe[CORE_LATENCY], less_than_zero}),
    .pop       (fb_ready),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fb_we   = !fifo_empty;
  assign fb_addr = fifo_out[FW-1:1];
  assign fb_data = fifo_out[0];
endmodule
